// File: rtl/deserializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : deserializer_if                                          |
// | Desc    : Serial-in / parallel-out bundle of the link receiver.    |
// |           master = serial source side, slave = deserializer side.  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface deserializer_if #(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int DATA_MOD_WIDTH = 4
);
   logic                      ser_data_i;
   logic                      ser_data_val_i;
   logic [DATA_BUS_WIDTH-1:0] deser_data_o;
   logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o;
   logic                      deser_data_val_o;
   logic                      busy_o;

   modport master (
      output ser_data_i,
      output ser_data_val_i,
      input  deser_data_o,
      input  deser_data_mod_o,
      input  deser_data_val_o,
      input  busy_o
   );

   modport slave (
      input  ser_data_i,
      input  ser_data_val_i,
      output deser_data_o,
      output deser_data_mod_o,
      output deser_data_val_o,
      output busy_o
   );
endinterface
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : deserializer                                             |
// | Desc    : Collects an MSB-first serial stream qualified by a valid |
// |           strobe into MSB-aligned words with a bit count and a     |
// |           one-cycle valid pulse. 1- and 2-bit bursts are dropped.  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module deserializer #(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int DATA_MOD_WIDTH = 4
) (
   input wire logic        clk_i,
   input wire logic        srst_i,
   deserializer_if.slave   bus
);

   typedef enum logic [0:0] {
      IDLE_S = 1'b0,
      RECV_S = 1'b1
   } state_t;

   // Counter is one bit wider than the mod output so a full word count fits.
   localparam int                    c_CNT_W    = DATA_MOD_WIDTH + 1;
   localparam logic [c_CNT_W-1:0]    c_LAST_IDX = c_CNT_W'(DATA_BUS_WIDTH - 1);
   localparam logic [c_CNT_W-1:0]    c_MIN_LEN  = c_CNT_W'(3);
   localparam logic [c_CNT_W-1:0]    c_ONE      = c_CNT_W'(1);

   state_t                    r_state;
   logic [c_CNT_W-1:0]        r_cnt;
   logic [DATA_BUS_WIDTH-1:0] r_buf;
   logic [DATA_BUS_WIDTH-1:0] r_data;
   logic [DATA_MOD_WIDTH-1:0] r_mod;
   logic                      r_val;

   logic [c_CNT_W-1:0]        w_shift;
   logic [DATA_BUS_WIDTH-1:0] w_bit;
   logic [DATA_BUS_WIDTH-1:0] w_word;

   // Place the incoming bit at DATA_BUS_WIDTH-1-count; in IDLE the counter
   // and buffer are zero, so the same path lands the first bit at the MSB.
   assign w_shift = c_LAST_IDX - r_cnt;
   assign w_bit   = {{(DATA_BUS_WIDTH-1){1'b0}}, bus.ser_data_i} << w_shift;
   assign w_word  = r_buf | w_bit;

   // Collection FSM with registered word, count and strobe outputs.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state <= IDLE_S;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_data  <= '0;
         r_mod   <= '0;
         r_val   <= 1'b0;
      end else begin
         r_val <= 1'b0;
         case (r_state)
            IDLE_S: begin
               if (bus.ser_data_val_i) begin
                  r_buf   <= w_word;
                  r_cnt   <= c_ONE;
                  r_state <= RECV_S;
               end
            end
            RECV_S: begin
               if (bus.ser_data_val_i) begin
                  if (r_cnt == c_LAST_IDX) begin
                     // Last bit of a full word: emit and go idle so a
                     // following valid bit opens the next word at once.
                     r_data  <= w_word;
                     r_mod   <= '0;
                     r_val   <= 1'b1;
                     r_buf   <= '0;
                     r_cnt   <= '0;
                     r_state <= IDLE_S;
                  end else begin
                     r_buf <= w_word;
                     r_cnt <= r_cnt + c_ONE;
                  end
               end else begin
                  // Strobe dropped: emit only legal (>= 3 bit) transfers.
                  if (r_cnt >= c_MIN_LEN) begin
                     r_data <= r_buf;
                     r_mod  <= r_cnt[DATA_MOD_WIDTH-1:0];
                     r_val  <= 1'b1;
                  end
                  r_buf   <= '0;
                  r_cnt   <= '0;
                  r_state <= IDLE_S;
               end
            end
            default: begin
               r_buf   <= '0;
               r_cnt   <= '0;
               r_state <= IDLE_S;
            end
         endcase
      end
   end

   assign bus.deser_data_o     = r_data;
   assign bus.deser_data_mod_o = r_mod;
   assign bus.deser_data_val_o = r_val;
   assign bus.busy_o           = (r_state == RECV_S);

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_deserializer                                          |
// | Desc    : Directed self-checking bench for deserializer.           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_deserializer;

   localparam int c_W = 16;
   localparam int c_M = 4;

   logic clk;
   logic srst;
   int   n_tests;
   int   n_fail;
   int   n_pulses;

   deserializer_if #(.DATA_BUS_WIDTH(c_W), .DATA_MOD_WIDTH(c_M)) bus ();

   deserializer #(.DATA_BUS_WIDTH(c_W), .DATA_MOD_WIDTH(c_M)) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count output pulses on the inactive edge.
   always @(negedge clk) begin
      if (bus.deser_data_val_o === 1'b1) n_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past one active edge; outputs settle before the next drive.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send n bits of w MSB first; for n < 16 drop valid afterwards. Then
   // check the emitted word/mod and the single-cycle pulse.
   task automatic xfer(input string tag, input logic [15:0] w, input int n,
                       input logic [15:0] exp_data, input logic [3:0] exp_mod);
      int p0;
      p0 = n_pulses;
      for (int i = 0; i < n; i++) begin
         bus.ser_data_val_i = 1'b1;
         bus.ser_data_i     = w[15-i];
         tick();
         if (i < n - 1 || n < c_W) check({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd1);
      end
      bus.ser_data_val_i = 1'b0;
      bus.ser_data_i     = 1'b0;
      if (n < c_W) tick();
      check({tag, "_val"},  {31'd0, bus.deser_data_val_o}, 32'd1);
      check({tag, "_data"}, {16'd0, bus.deser_data_o}, {16'd0, exp_data});
      check({tag, "_mod"},  {28'd0, bus.deser_data_mod_o}, {28'd0, exp_mod});
      tick();
      check({tag, "_val_off"}, {31'd0, bus.deser_data_val_o}, 32'd0);
      check({tag, "_hold"}, {16'd0, bus.deser_data_o}, {16'd0, exp_data});
      check({tag, "_idle"}, {31'd0, bus.busy_o}, 32'd0);
      check({tag, "_npulse"}, n_pulses - p0, 32'd1);
   endtask

   initial begin
      int p0;
      logic [15:0] stream0;
      logic [15:0] stream1;
      n_tests = 0;
      n_fail  = 0;
      n_pulses = 0;
      srst = 1'b1;
      bus.ser_data_i     = 1'b1;
      bus.ser_data_val_i = 1'b0;

      // Reset held 3 cycles with valid toggling.
      for (int i = 0; i < 3; i++) begin
         bus.ser_data_val_i = ~bus.ser_data_val_i;
         tick();
         check("rst_val", {31'd0, bus.deser_data_val_o}, 32'd0);
      end
      check("rst_data", {16'd0, bus.deser_data_o}, 32'd0);
      check("rst_mod",  {28'd0, bus.deser_data_mod_o}, 32'd0);
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      srst = 1'b0;
      bus.ser_data_val_i = 1'b0;
      tick();
      check("rst_npulse", n_pulses, 32'd0);

      // Full word.
      xfer("full", 16'hA5C3, 16, 16'hA5C3, 4'd0);

      // Partial word 1,0,1,1,0.
      xfer("part", 16'hB000, 5, 16'hB000, 4'd5);

      // Illegal 2-bit transfer: silently dropped.
      p0 = n_pulses;
      for (int i = 0; i < 2; i++) begin
         bus.ser_data_val_i = 1'b1;
         bus.ser_data_i     = 1'b1;
         tick();
      end
      bus.ser_data_val_i = 1'b0;
      tick();
      tick();
      check("ill_npulse", n_pulses - p0, 32'd0);
      check("ill_data", {16'd0, bus.deser_data_o}, 32'h0000B000);
      check("ill_mod",  {28'd0, bus.deser_data_mod_o}, 32'd5);
      check("ill_busy", {31'd0, bus.busy_o}, 32'd0);

      // Continuous 32-bit stream: pulses after bit 16 and bit 32 only.
      stream0 = 16'h1234;
      stream1 = 16'hABCD;
      p0 = n_pulses;
      for (int i = 0; i < 32; i++) begin
         bus.ser_data_val_i = 1'b1;
         bus.ser_data_i     = (i < 16) ? stream0[15-i] : stream1[31-i];
         tick();
         if (i == 15) begin
            check("cont_val0",  {31'd0, bus.deser_data_val_o}, 32'd1);
            check("cont_data0", {16'd0, bus.deser_data_o}, 32'h00001234);
            check("cont_mod0",  {28'd0, bus.deser_data_mod_o}, 32'd0);
         end else if (i == 31) begin
            check("cont_val1",  {31'd0, bus.deser_data_val_o}, 32'd1);
            check("cont_data1", {16'd0, bus.deser_data_o}, 32'h0000ABCD);
            check("cont_mod1",  {28'd0, bus.deser_data_mod_o}, 32'd0);
         end
      end
      bus.ser_data_val_i = 1'b0;
      tick();
      check("cont_npulse", n_pulses - p0, 32'd2);

      // Reset after 7 bits discards the partial word.
      p0 = n_pulses;
      for (int i = 0; i < 7; i++) begin
         bus.ser_data_val_i = 1'b1;
         bus.ser_data_i     = 1'b1;
         tick();
      end
      srst = 1'b1;
      tick();
      srst = 1'b0;
      bus.ser_data_val_i = 1'b0;
      check("mrst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("mrst_data", {16'd0, bus.deser_data_o}, 32'd0);
      tick();
      check("mrst_npulse", n_pulses - p0, 32'd0);
      xfer("post_rst", 16'hE000, 3, 16'hE000, 4'd3);

      // Loopback-style frames with mod 0, 3 and 15.
      xfer("lb_m0",  16'h5A96, 16, 16'h5A96, 4'd0);
      xfer("lb_m3",  16'hC7FF, 3,  16'hC000, 4'd3);
      xfer("lb_m15", 16'h9BDF, 15, 16'h9BDE, 4'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
